// File: rtl/ax_btb_pred_select_if.sv
// ax_btb_pred_select_if
//   Bundles the fetch-group input side (BTB read results plus valid/ready)
//   and the redirect output side (buffer head plus valid/ready) of
//   ax_btb_pred_select.
//   slave  : the selector's view (consumes the fetch group, produces the head).
//   master : the environment's view (produces the fetch group, consumes the head).
// Handshake: a transfer happens on a rising clk edge where valid && ready.
//   The producer holds its payload stable while valid && !ready. ready never
//   depends combinationally on valid.
interface ax_btb_pred_select_if #(
  parameter int FETCH_WIDTH = 2,
  parameter int PC_WIDTH    = 32
);
  localparam int LANE_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

  // fetch-group side
  logic                            inValid;
  logic                            inReady;
  logic [PC_WIDTH-1:0]             inPC;
  logic [FETCH_WIDTH-1:0]          inLaneValid;
  logic [FETCH_WIDTH-1:0]          axbtbHit;
  logic [FETCH_WIDTH*PC_WIDTH-1:0] axbtbOut;
  logic [FETCH_WIDTH-1:0]          axreadIsCondBr;

  // redirect output side
  logic                            outValid;
  logic                            outReady;
  logic [PC_WIDTH-1:0]             outPC;
  logic [FETCH_WIDTH-1:0]          outLaneMask;
  logic                            outRedirect;
  logic [PC_WIDTH-1:0]             outTarget;
  logic [LANE_W-1:0]               outLane;
  logic                            outIsCondBr;

  modport slave (
    input  inValid, inPC, inLaneValid, axbtbHit, axbtbOut, axreadIsCondBr,
    output inReady,
    output outValid, outPC, outLaneMask, outRedirect, outTarget, outLane, outIsCondBr,
    input  outReady
  );

  modport master (
    output inValid, inPC, inLaneValid, axbtbHit, axbtbOut, axreadIsCondBr,
    input  inReady,
    input  outValid, outPC, outLaneMask, outRedirect, outTarget, outLane, outIsCondBr,
    output outReady
  );
endinterface

// File: rtl/ax_btb_pred_select.sv
// ax_btb_pred_select
//   Consumes per-lane approximate-BTB read results for a fetch group, picks
//   the first valid lane with a hit as the predicted-taken branch, trims the
//   lane mask after it and queues {PC, mask, redirect, target, lane, isCondBr}
//   into a 2-entry output buffer. After a redirect is queued, groups whose PC
//   is not the predicted target are wrong-path and are dropped.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         empties the buffer and returns to IDLE; beats accept
//   bus           ax_btb_pred_select_if.slave (input group / output head)
//   hitCount      saturating count of queued groups carrying a redirect
//   discardCount  saturating count of dropped wrong-path groups
//   state_dbg     current FSM state (0 = IDLE, 1 = WAIT_TARGET)
module ax_btb_pred_select #(
  parameter int FETCH_WIDTH = 2,
  parameter int PC_WIDTH    = 32,
  parameter int INSN_BYTES  = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int DEPTH       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  ax_btb_pred_select_if.slave   bus,
  output logic [CNT_WIDTH-1:0]  hitCount,
  output logic [CNT_WIDTH-1:0]  discardCount,
  output logic                  state_dbg
);
  localparam int LANE_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int PTR_W  = 1;
  localparam int CW     = 2;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH != 2) begin : g_bad_depth
    $error("ax_btb_pred_select: DEPTH must be 2");
  end
  if (INSN_BYTES < 1) begin : g_bad_insn_bytes
    $error("ax_btb_pred_select: INSN_BYTES must be positive");
  end

  typedef enum logic {IDLE = 1'b0, WAIT_TARGET = 1'b1} state_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [FETCH_WIDTH-1:0] mask;
    logic                   redirect;
    logic [PC_WIDTH-1:0]    target;
    logic [LANE_W-1:0]      lane;
    logic                   is_cond_br;
  } entry_t;

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pend_target, pend_next;

  entry_t              mem [DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]       count;

  logic                sel_found;
  logic [LANE_W-1:0]   sel_lane;
  entry_t              new_entry;
  entry_t              head;

  logic                accept, drop, push, pop;

  // Lane selection: the lowest lane that is both fetch-valid and a BTB hit.
  always_comb begin
    sel_found = 1'b0;
    sel_lane  = '0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (bus.inLaneValid[i] && bus.axbtbHit[i]) begin
        sel_found = 1'b1;
        sel_lane  = LANE_W'(i);
      end
    end

    new_entry          = '0;
    new_entry.pc       = bus.inPC;
    new_entry.mask     = bus.inLaneValid;
    new_entry.redirect = sel_found;
    if (sel_found) begin
      // Lanes after the taken branch are on the wrong path.
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (i > int'(sel_lane)) new_entry.mask[i] = 1'b0;
      end
      new_entry.target     = bus.axbtbOut[int'(sel_lane)*PC_WIDTH +: PC_WIDTH];
      new_entry.lane       = sel_lane;
      new_entry.is_cond_br = bus.axreadIsCondBr[sel_lane];
    end
  end

  // No bypass: a full buffer refuses input even when popping this cycle.
  assign bus.inReady = (count < FULL) && !flush && !rst;
  assign accept      = bus.inValid && bus.inReady;
  assign drop        = accept && (state == WAIT_TARGET) && (bus.inPC != pend_target);
  assign push        = accept && !drop;
  assign pop         = bus.outValid && bus.outReady && !flush;

  // Buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  assign head = mem[rd_ptr];

  always_comb begin
    bus.outValid    = (count != '0);
    bus.outPC       = '0;
    bus.outLaneMask = '0;
    bus.outRedirect = 1'b0;
    bus.outTarget   = '0;
    bus.outLane     = '0;
    bus.outIsCondBr = 1'b0;
    if (count != '0) begin
      bus.outPC       = head.pc;
      bus.outLaneMask = head.mask;
      bus.outRedirect = head.redirect;
      bus.outTarget   = head.target;
      bus.outLane     = head.lane;
      bus.outIsCondBr = head.is_cond_br;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pend_target <= '0;
    end else begin
      state       <= state_next;
      pend_target <= pend_next;
    end
  end

  // FSM next state. A queued redirect (from either state) arms the wrong-path
  // filter on its target; a queued non-redirect group in WAIT_TARGET is the
  // target group itself and disarms it. flush keeps pend_target.
  always_comb begin
    state_next = state;
    pend_next  = pend_target;
    if (flush) begin
      state_next = IDLE;
    end else if (push && new_entry.redirect) begin
      state_next = WAIT_TARGET;
      pend_next  = new_entry.target;
    end else if (push && (state == WAIT_TARGET)) begin
      state_next = IDLE;
    end
  end

  assign state_dbg = state;

  // Saturating statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      hitCount     <= '0;
      discardCount <= '0;
    end else begin
      if (push && new_entry.redirect && (hitCount != '1))
        hitCount <= hitCount + CNT_WIDTH'(1);
      if (drop && (discardCount != '1))
        discardCount <= discardCount + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_ax_btb_pred_select.sv
module tb_ax_btb_pred_select;
  localparam int FW = 2;
  localparam int PW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [CW-1:0] hitCount;
  logic [CW-1:0] discardCount;
  logic          state_dbg;

  ax_btb_pred_select_if #(.FETCH_WIDTH(FW), .PC_WIDTH(PW)) bus_if ();

  ax_btb_pred_select #(
    .FETCH_WIDTH(FW), .PC_WIDTH(PW), .INSN_BYTES(4), .CNT_WIDTH(CW), .DEPTH(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (bus_if.slave),
    .hitCount     (hitCount),
    .discardCount (discardCount),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [PW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [PW-1:0] pc, input logic [FW-1:0] lv,
                       input logic [FW-1:0] hit, input logic [PW-1:0] t0,
                       input logic [PW-1:0] t1, input logic [FW-1:0] cb);
    bus_if.inValid        = v;
    bus_if.inPC           = pc;
    bus_if.inLaneValid    = lv;
    bus_if.axbtbHit       = hit;
    bus_if.axbtbOut       = {t1, t0};
    bus_if.axreadIsCondBr = cb;
    #1;
  endtask

  task automatic idle_in();
    drive(1'b0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic check_head(input string tag, input logic [PW-1:0] pc, input logic [FW-1:0] mask,
                            input logic red, input logic [PW-1:0] tgt, input logic lane,
                            input logic cb);
    check({tag, "_valid"},  64'(bus_if.outValid),    64'(1'b1));
    check({tag, "_pc"},     64'(bus_if.outPC),       64'(pc));
    check({tag, "_mask"},   64'(bus_if.outLaneMask), 64'(mask));
    check({tag, "_redir"},  64'(bus_if.outRedirect), 64'(red));
    check({tag, "_target"}, 64'(bus_if.outTarget),   64'(tgt));
    check({tag, "_lane"},   64'(bus_if.outLane),     64'(lane));
    check({tag, "_condbr"}, 64'(bus_if.outIsCondBr), 64'(cb));
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus_if.outReady = 1'b1;
    idle_in();
    check("rst_inready", 64'(bus_if.inReady), 64'(1'b0));
    tick();
    tick();
    check("rst_outvalid", 64'(bus_if.outValid), 64'(1'b0));
    check("rst_outpc",    64'(bus_if.outPC),    64'(0));
    check("rst_hit",      64'(hitCount),        64'(0));
    check("rst_disc",     64'(discardCount),    64'(0));
    check("rst_state",    64'(state_dbg),       64'(0));
    rst = 1'b0;
    #1;
    check("post_rst_inready", 64'(bus_if.inReady), 64'(1'b1));

    // 1: lane 0 hit redirects and trims lane 1
    drive(1'b1, 32'h1000, 2'b11, 2'b01, 32'h2000, 32'h3000, 2'b01);
    tick();
    idle_in();
    check_head("t1", 32'h1000, 2'b01, 1'b1, 32'h2000, 1'b0, 1'b1);
    check("t1_hit",   64'(hitCount),  64'(1));
    check("t1_state", 64'(state_dbg), 64'(1));

    // 2: wrong-path group dropped, target group queued, back to IDLE
    drive(1'b1, 32'h1008, 2'b11, 2'b00, 32'h0, 32'h0, 2'b00);
    tick();
    check("t2_drop_valid", 64'(bus_if.outValid), 64'(1'b0));
    check("t2_disc",       64'(discardCount),    64'(1));
    check("t2_state_wait", 64'(state_dbg),       64'(1));
    drive(1'b1, 32'h2000, 2'b11, 2'b00, 32'h0, 32'h0, 2'b00);
    tick();
    idle_in();
    check_head("t2", 32'h2000, 2'b11, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t2_state_idle", 64'(state_dbg), 64'(0));
    tick();
    check("t2_empty", 64'(bus_if.outValid), 64'(1'b0));

    // 3: backpressure, full buffer, no bypass, FIFO order
    bus_if.outReady = 1'b0;
    drive(1'b1, 32'h3000, 2'b11, 2'b00, 32'h0, 32'h0, 2'b00);
    tick();
    exp_q.push_back(32'h3000);
    drive(1'b1, 32'h3008, 2'b11, 2'b00, 32'h0, 32'h0, 2'b00);
    tick();
    exp_q.push_back(32'h3008);
    drive(1'b1, 32'h3010, 2'b11, 2'b00, 32'h0, 32'h0, 2'b00);
    check("t3_full_inready", 64'(bus_if.inReady), 64'(1'b0));
    tick();
    check("t3_hold_pc",    64'(bus_if.outPC),    64'(exp_q[0]));
    check("t3_hold_valid", 64'(bus_if.outValid), 64'(1'b1));
    bus_if.outReady = 1'b1;
    #1;
    check("t3_nobypass", 64'(bus_if.inReady), 64'(1'b0));
    tick();
    void'(exp_q.pop_front());
    check("t3_pop1_pc",   64'(bus_if.outPC),   64'(exp_q[0]));
    check("t3_pop1_rdy",  64'(bus_if.inReady), 64'(1'b1));
    tick();
    exp_q.push_back(32'h3010);
    void'(exp_q.pop_front());
    idle_in();
    check("t3_pop2_pc",   64'(bus_if.outPC),   64'(exp_q[0]));
    tick();
    void'(exp_q.pop_front());
    check("t3_empty",     64'(bus_if.outValid), 64'(1'b0));
    check("t3_zero_pc",   64'(bus_if.outPC),    64'(0));
    check("t3_q_drained", 64'(exp_q.size()),    64'(0));

    // 4: two redirects buffered in WAIT_TARGET, then flush
    bus_if.outReady = 1'b0;
    drive(1'b1, 32'h4000, 2'b11, 2'b10, 32'hDEAD, 32'h5000, 2'b00);
    tick();
    drive(1'b1, 32'h5000, 2'b01, 2'b01, 32'h6000, 32'h0, 2'b00);
    tick();
    check_head("t4", 32'h4000, 2'b11, 1'b1, 32'h5000, 1'b1, 1'b0);
    check("t4_hit",   64'(hitCount),  64'(3));
    check("t4_state", 64'(state_dbg), 64'(1));
    flush = 1'b1;
    drive(1'b1, 32'h6000, 2'b11, 2'b00, 32'h0, 32'h0, 2'b00);
    check("t4_flush_inready", 64'(bus_if.inReady), 64'(1'b0));
    tick();
    flush = 1'b0;
    idle_in();
    check("t4_flush_valid", 64'(bus_if.outValid), 64'(1'b0));
    check("t4_flush_state", 64'(state_dbg),       64'(0));
    check("t4_flush_hit",   64'(hitCount),        64'(3));
    check("t4_flush_disc",  64'(discardCount),    64'(1));
    tick();
    check("t4_no_enq", 64'(bus_if.outValid), 64'(1'b0));

    // 5: hitCount saturation (4-bit counter, 3 -> 15 in 12 redirects)
    bus_if.outReady = 1'b1;
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 32'h8000 + 32'(k) * 32'h100, 2'b01, 2'b01,
            32'h8000 + 32'(k + 1) * 32'h100, 32'h0, 2'b00);
      tick();
    end
    check("t5_hit_max", 64'(hitCount), 64'(4'hF));
    drive(1'b1, 32'h8C00, 2'b01, 2'b01, 32'h8D00, 32'h0, 2'b00);
    tick();
    idle_in();
    check("t5_hit_sat",   64'(hitCount),         64'(4'hF));
    check("t5_last_head", 64'(bus_if.outTarget), 64'(32'h8D00));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;

    // 6: reset with a full buffer, then 1-cycle latency, lane-0-invalid hit
    bus_if.outReady = 1'b0;
    drive(1'b1, 32'h9000, 2'b11, 2'b00, 32'h0, 32'h0, 2'b00);
    tick();
    drive(1'b1, 32'h9008, 2'b11, 2'b00, 32'h0, 32'h0, 2'b00);
    tick();
    idle_in();
    check("t6_full_rdy", 64'(bus_if.inReady), 64'(1'b0));
    rst = 1'b1;
    #1;
    tick();
    check("t6_rst_valid", 64'(bus_if.outValid), 64'(1'b0));
    check("t6_rst_hit",   64'(hitCount),        64'(0));
    check("t6_rst_disc",  64'(discardCount),    64'(0));
    check("t6_rst_rdy",   64'(bus_if.inReady),  64'(1'b0));
    rst = 1'b0;
    bus_if.outReady = 1'b1;
    drive(1'b1, 32'hA000, 2'b10, 2'b11, 32'hDEAD, 32'hB000, 2'b10);
    tick();
    idle_in();
    check_head("t6", 32'hA000, 2'b10, 1'b1, 32'hB000, 1'b1, 1'b1);
    check("t6_hit", 64'(hitCount), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
